icmp_echo_requester: RTL and testbench

Initiator side of the ICMP echo link: builds an IPv4 ICMP Echo Request, computes both checksums, and transmits it on an Avalon-ST source. It then watches an Avalon-ST sink for the matching Echo Reply and reports round-trip cycles or timeout. It sits opposite the echo responder in the ping TUN/TAP example; both streams carry raw IPv4 packets.

---
 rtl/icmp_pkg.sv | 33 +++
 rtl/icmp_csum_acc.sv | 39 +++
 rtl/icmp_echo_requester.sv | 222 ++++++++++++++++++++++
 tb/tb_icmp_echo_requester.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/icmp_pkg.sv
// Shared types, protocol constants and byte-order helpers for the ICMP echo requester.
package icmp_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_SEND = 2'd2,
        S_WAIT = 2'd3
    } state_t;

    localparam logic [7:0] ICMP_ECHO_REQ   = 8'd8;
    localparam logic [7:0] ICMP_ECHO_REPLY = 8'd0;
    localparam logic [7:0] IP_PROTO_ICMP   = 8'd1;
    localparam logic [7:0] IP_TTL          = 8'd64;
    localparam logic [4:0] IP_HDR_WORDS    = 5'd5;
    localparam logic [4:0] ICMP_HDR_WORDS  = 5'd2;

    function automatic logic [15:0] byteswap16(input logic [15:0] x);
        return {x[7:0], x[15:8]};
    endfunction

    // Numeric big-endian value to lane order (first wire byte in [7:0]).
    function automatic logic [31:0] byteswap32(input logic [31:0] x);
        return {byteswap16(x[15:0]), byteswap16(x[31:16])};
    endfunction

    function automatic logic [15:0] ones_add16(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[15:0] + {15'd0, s[16]};
    endfunction

endpackage

// File: rtl/icmp_csum_acc.sv
// 16-bit ones'-complement accumulator; adds both network-order halves of a lane-ordered word per cycle.
module icmp_csum_acc
    import icmp_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clear,
    input  logic        enable,
    input  logic [31:0] word,
    output logic [15:0] csum
);

    logic [15:0] acc_r;
    logic [15:0] acc_next_s;

    // Next accumulator value; end-around carry keeps it folded every cycle
    always_comb begin
        if (clear) begin
            acc_next_s = 16'h0000;
        end else if (enable) begin
            acc_next_s = ones_add16(ones_add16(acc_r, byteswap16(word[15:0])),
                                    byteswap16(word[31:16]));
        end else begin
            acc_next_s = acc_r;
        end
    end

    // Accumulator register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_r <= 16'h0000;
        end else begin
            acc_r <= acc_next_s;
        end
    end

    assign csum = ~acc_r;

endmodule

// File: rtl/icmp_echo_requester.sv
// ICMP echo initiator: builds and checksums an IPv4 Echo Request, streams it out,
// then waits for the matching Echo Reply and reports round-trip cycles or timeout.
module icmp_echo_requester
    import icmp_pkg::*;
#(
    parameter int unsigned PAYLOAD_WORDS_MAX = 16,
    parameter int unsigned TIMEOUT_CYCLES    = 1000000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [31:0] src_ip,
    input  logic [31:0] dst_ip,
    input  logic [15:0] ident,
    input  logic [4:0]  payload_words,
    output logic        busy,
    output logic        done,
    output logic        reply_ok,
    output logic        timed_out,
    output logic [31:0] rtt_cycles,
    output logic [15:0] seq_num,
    output logic [31:0] tx_data,
    output logic [1:0]  tx_empty,
    output logic        tx_valid,
    output logic        tx_startofpacket,
    output logic        tx_endofpacket,
    input  logic        tx_ready,
    input  logic [31:0] rx_data,
    input  logic [1:0]  rx_empty,
    input  logic        rx_valid,
    input  logic        rx_startofpacket,
    input  logic        rx_endofpacket,
    output logic        rx_ready
);

    localparam logic [4:0]  P_MAX = 5'(PAYLOAD_WORDS_MAX);
    localparam logic [31:0] T_MAX = 32'(TIMEOUT_CYCLES);

    state_t      state_r, state_next_s;
    logic [31:0] src_r, dst_r, cnt_r, rtt_r;
    logic [15:0] ident_r, seq_r, seq_num_r;
    logic [4:0]  n_words_r, idx_r, p_clamp_s;
    logic        done_r, reply_ok_r, timed_out_r, rx_ready_r;
    logic [2:0]  rx_idx_r, rx_idx_s;
    logic        rx_ok_r, rx_ok_s, rx_chk_s, rx_len_ok_s, rx_beat_s;
    logic        last_s, match_s, timeout_s;
    logic [31:0] word_s, word6_s;
    logic [15:0] ip_csum_s, icmp_csum_s, ip_fld_s, icmp_fld_s;
    logic [3:0]  pay_idx_s;
    logic [7:0]  pay_byte_s;

    assign p_clamp_s = (payload_words > P_MAX) ? P_MAX : payload_words;
    assign last_s    = (idx_r == (n_words_r - 5'd1));
    assign rx_beat_s = rx_valid && rx_ready_r;
    assign timeout_s = (state_r == S_WAIT) && (cnt_r >= T_MAX);
    assign word6_s   = {byteswap16(seq_r), byteswap16(ident_r)};

    icmp_csum_acc u_ip_acc (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (state_r == S_IDLE),
        .enable  ((state_r == S_CALC) && (idx_r < IP_HDR_WORDS)),
        .word    (word_s),
        .csum    (ip_csum_s)
    );

    icmp_csum_acc u_icmp_acc (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (state_r == S_IDLE),
        .enable  ((state_r == S_CALC) && (idx_r >= IP_HDR_WORDS)),
        .word    (word_s),
        .csum    (icmp_csum_s)
    );

    // Packet word at idx_r; checksum fields read as zero while they are being summed
    always_comb begin
        ip_fld_s   = (state_r == S_SEND) ? ip_csum_s : 16'h0000;
        icmp_fld_s = (state_r == S_SEND) ? icmp_csum_s : 16'h0000;
        pay_idx_s  = 4'(idx_r - (IP_HDR_WORDS + ICMP_HDR_WORDS));
        pay_byte_s = {2'b00, pay_idx_s, 2'b00};
        case (idx_r)
            5'd0:    word_s = {byteswap16({9'd0, n_words_r, 2'b00}), 8'h00, 8'h45};
            5'd1:    word_s = {16'h0000, byteswap16(seq_r)};
            5'd2:    word_s = {byteswap16(ip_fld_s), IP_PROTO_ICMP, IP_TTL};
            5'd3:    word_s = byteswap32(src_r);
            5'd4:    word_s = byteswap32(dst_r);
            5'd5:    word_s = {byteswap16(icmp_fld_s), 8'h00, ICMP_ECHO_REQ};
            5'd6:    word_s = word6_s;
            default: word_s = {pay_byte_s | 8'd3, pay_byte_s | 8'd2, pay_byte_s | 8'd1, pay_byte_s};
        endcase
    end

    // Reply matcher; a beat outside S_WAIT poisons the rest of its packet
    always_comb begin
        rx_idx_s = rx_startofpacket ? 3'd0 : rx_idx_r;
        case (rx_idx_s)
            3'd3:    rx_chk_s = (rx_data == byteswap32(dst_r));
            3'd4:    rx_chk_s = (rx_data == byteswap32(src_r));
            3'd5:    rx_chk_s = (rx_data[7:0] == ICMP_ECHO_REPLY);
            3'd6:    rx_chk_s = (rx_data == word6_s);
            default: rx_chk_s = 1'b1;
        endcase
        rx_ok_s     = (rx_startofpacket ? 1'b1 : rx_ok_r) && rx_chk_s && (state_r == S_WAIT);
        rx_len_ok_s = (rx_idx_s == 3'd7) || ((rx_idx_s == 3'd6) && (rx_empty == 2'd0));
        match_s     = rx_beat_s && rx_endofpacket && rx_ok_s && rx_len_ok_s;
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic
    always_comb begin
        case (state_r)
            S_IDLE:  state_next_s = start ? S_CALC : S_IDLE;
            S_CALC:  state_next_s = last_s ? S_SEND : S_CALC;
            S_SEND:  state_next_s = (tx_ready && last_s) ? S_WAIT : S_SEND;
            S_WAIT:  state_next_s = (match_s || timeout_s) ? S_IDLE : S_WAIT;
            default: state_next_s = S_IDLE;
        endcase
    end

    // Output decode; tx signals are forced to zero outside S_SEND
    always_comb begin
        busy             = (state_r != S_IDLE);
        tx_empty         = 2'd0;
        tx_valid         = 1'b0;
        tx_startofpacket = 1'b0;
        tx_endofpacket   = 1'b0;
        tx_data          = 32'd0;
        case (state_r)
            S_SEND: begin
                tx_valid         = 1'b1;
                tx_startofpacket = (idx_r == 5'd0);
                tx_endofpacket   = last_s;
                tx_data          = word_s;
            end
            default: begin
                tx_valid = 1'b0;
            end
        endcase
    end

    // Request latches, word index, round-trip counter and result registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            src_r <= 32'd0; dst_r <= 32'd0; ident_r <= 16'd0;
            n_words_r <= 5'd0; idx_r <= 5'd0; cnt_r <= 32'd0; rtt_r <= 32'd0;
            seq_r <= 16'd0; seq_num_r <= 16'd0;
            done_r <= 1'b0; reply_ok_r <= 1'b0; timed_out_r <= 1'b0; rx_ready_r <= 1'b0;
        end else begin
            done_r     <= 1'b0;
            rx_ready_r <= 1'b1;
            case (state_r)
                S_IDLE: begin
                    idx_r <= 5'd0;
                    if (start) begin
                        src_r       <= src_ip;
                        dst_r       <= dst_ip;
                        ident_r     <= ident;
                        n_words_r   <= IP_HDR_WORDS + ICMP_HDR_WORDS + p_clamp_s;
                        seq_num_r   <= seq_r;
                        reply_ok_r  <= 1'b0;
                        timed_out_r <= 1'b0;
                    end
                end
                S_CALC: idx_r <= last_s ? 5'd0 : idx_r + 5'd1;
                S_SEND: begin
                    if (tx_ready) begin
                        idx_r <= last_s ? 5'd0 : idx_r + 5'd1;
                        if (last_s) begin
                            cnt_r <= 32'd1;
                        end
                    end
                end
                S_WAIT: begin
                    if (cnt_r != 32'hFFFF_FFFF) begin
                        cnt_r <= cnt_r + 32'd1;
                    end
                    if (match_s || timeout_s) begin
                        done_r      <= 1'b1;
                        reply_ok_r  <= match_s;
                        timed_out_r <= !match_s;
                        rtt_r       <= cnt_r;
                        seq_r       <= seq_r + 16'd1;
                    end
                end
                default: idx_r <= 5'd0;
            endcase
        end
    end

    // RX word position and running match flag
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_idx_r <= 3'd0;
            rx_ok_r  <= 1'b1;
        end else if (rx_beat_s) begin
            if (rx_endofpacket) begin
                rx_idx_r <= 3'd0;
                rx_ok_r  <= 1'b1;
            end else begin
                rx_idx_r <= (rx_idx_s == 3'd7) ? 3'd7 : rx_idx_s + 3'd1;
                rx_ok_r  <= rx_ok_s;
            end
        end
    end

    assign done       = done_r;
    assign reply_ok   = reply_ok_r;
    assign timed_out  = timed_out_r;
    assign rtt_cycles = rtt_r;
    assign seq_num    = seq_num_r;
    assign rx_ready   = rx_ready_r;

endmodule

// File: tb/tb_icmp_echo_requester.sv
// Directed bench for icmp_echo_requester with a behavioural echo responder.
module tb_icmp_echo_requester;

    logic        clk = 1'b0;
    logic        reset_n, start, tx_ready;
    logic [31:0] src_ip, dst_ip, rx_data;
    logic [15:0] ident;
    logic [4:0]  payload_words;
    logic [1:0]  rx_empty, tx_empty;
    logic        rx_valid, rx_startofpacket, rx_endofpacket;
    logic        busy, done, reply_ok, timed_out, tx_valid, tx_startofpacket, tx_endofpacket, rx_ready;
    logic [31:0] rtt_cycles, tx_data;
    logic [15:0] seq_num;

    icmp_echo_requester #(.PAYLOAD_WORDS_MAX(16), .TIMEOUT_CYCLES(100)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .src_ip(src_ip), .dst_ip(dst_ip),
        .ident(ident), .payload_words(payload_words), .busy(busy), .done(done),
        .reply_ok(reply_ok), .timed_out(timed_out), .rtt_cycles(rtt_cycles), .seq_num(seq_num),
        .tx_data(tx_data), .tx_empty(tx_empty), .tx_valid(tx_valid),
        .tx_startofpacket(tx_startofpacket), .tx_endofpacket(tx_endofpacket), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_empty(rx_empty), .rx_valid(rx_valid),
        .rx_startofpacket(rx_startofpacket), .rx_endofpacket(rx_endofpacket), .rx_ready(rx_ready)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests_run = 0, tests_failed = 0;
    int sop_cnt = 0, eop_cnt = 0, done_cnt = 0, valid_drop = 0;
    int sop_cyc = 0, eop_cyc = 0, done_cyc = 0, start_cyc = 0, rx_eop_cyc = 0;
    bit in_pkt = 1'b0;
    logic [31:0] tx_words[$];
    logic [31:0] run1[$];
    logic [31:0] reply[$];
    logic [31:0] tmp;

    // TX/done monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (!reset_n) begin
            in_pkt = 1'b0;
        end else begin
            if (in_pkt && !tx_valid) valid_drop++;
            if (tx_valid && tx_ready) begin
                tx_words.push_back(tx_data);
                if (tx_startofpacket) begin sop_cnt++; sop_cyc = cyc; in_pkt = 1'b1; end
                if (tx_endofpacket)   begin eop_cnt++; eop_cyc = cyc; in_pkt = 1'b0; end
            end
            if (done) begin done_cnt++; done_cyc = cyc; end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic pulse_start(input logic [4:0] p);
        payload_words = p;
        start = 1'b1;
        start_cyc = cyc;
        tick(1);
        start = 1'b0;
    endtask

    task automatic wait_eop(input int target);
        int k = 0;
        while (eop_cnt < target && k < 2000) begin tick(1); k++; end
        check("eop_seen", 32'(eop_cnt >= target), 32'd1);
        while (tx_words.size() < 24) tx_words.push_back(32'd0);
    endtask

    task automatic wait_done(input int target);
        int k = 0;
        while (done_cnt < target && k < 2000) begin tick(1); k++; end
        check("done_seen", 32'(done_cnt >= target), 32'd1);
    endtask

    task automatic send_pkt(input logic [31:0] w[$]);
        for (int i = 0; i < w.size(); i++) begin
            rx_valid = 1'b1;
            rx_data = w[i];
            rx_empty = 2'd0;
            rx_startofpacket = (i == 0);
            rx_endofpacket = (i == w.size() - 1);
            if (rx_endofpacket) rx_eop_cyc = cyc;
            tick(1);
        end
        rx_valid = 1'b0; rx_startofpacket = 1'b0; rx_endofpacket = 1'b0;
    endtask

    // Echo responder: swap addresses, set type to Echo Reply
    task automatic make_reply(input int n);
        reply.delete();
        for (int i = 0; i < n; i++) reply.push_back(tx_words[i]);
        tmp = reply[3]; reply[3] = reply[4]; reply[4] = tmp;
        reply[5] = reply[5] & 32'hFFFF_FF00;
    endtask

    function automatic logic [15:0] ocsum(input logic [31:0] w[$], input int lo, input int hi);
        logic [31:0] s = 32'd0;
        for (int i = lo; i <= hi; i++)
            s = s + {16'd0, w[i][7:0], w[i][15:8]} + {16'd0, w[i][23:16], w[i][31:24]};
        while (s[31:16] != 16'd0) s = {16'd0, s[15:0]} + {16'd0, s[31:16]};
        return s[15:0];
    endfunction

    initial begin
        int s0, e0, d0, diff;
        reset_n = 1'b0; start = 1'b0; tx_ready = 1'b1;
        src_ip = 32'h0A00_0001; dst_ip = 32'h0A00_0002; ident = 16'h1234; payload_words = 5'd4;
        rx_valid = 1'b0; rx_data = 32'd0; rx_empty = 2'd0; rx_startofpacket = 1'b0; rx_endofpacket = 1'b0;
        tick(3);
        check("rst_flags", {24'd0, busy, done, reply_ok, timed_out, tx_valid, tx_startofpacket, tx_endofpacket, rx_ready}, 32'd0);
        check("rst_data", tx_data | rtt_cycles | {16'd0, seq_num} | {30'd0, tx_empty}, 32'd0);
        reset_n = 1'b1;
        tick(2);
        check("rx_ready_after_rst", {31'd0, rx_ready}, 32'd1);
        check("idle_busy", {31'd0, busy}, 32'd0);

        // Basic frame, no stalls
        tx_words.delete(); s0 = sop_cnt; e0 = eop_cnt;
        pulse_start(5'd4);
        check("busy_after_start", {31'd0, busy}, 32'd1);
        wait_eop(e0 + 1);
        check("r1_words", tx_words.size(), 32'd24);
        check("r1_sop_cnt", sop_cnt - s0, 32'd1);
        check("r1_eop_cnt", eop_cnt - e0, 32'd1);
        check("r1_first_valid", sop_cyc - start_cyc, 32'd12);
        check("r1_w0", tx_words[0], 32'h2C00_0045);
        check("r1_w1", tx_words[1], 32'h0000_0000);
        check("r1_w2", tx_words[2], 32'hCF66_0140);
        check("r1_w3", tx_words[3], 32'h0100_000A);
        check("r1_w4", tx_words[4], 32'h0200_000A);
        check("r1_w5", tx_words[5], 32'h8BAD_0008);
        check("r1_w6", tx_words[6], 32'h0000_3412);
        check("r1_w7", tx_words[7], 32'h0302_0100);
        check("r1_w10", tx_words[10], 32'h0F0E_0D0C);
        check("r1_ip_sum", {16'd0, ocsum(tx_words, 0, 4)}, 32'h0000_FFFF);
        check("r1_icmp_sum", {16'd0, ocsum(tx_words, 5, 10)}, 32'h0000_FFFF);
        run1.delete();
        for (int i = 0; i < 11; i++) run1.push_back(tx_words[i]);
        make_reply(11);
        d0 = done_cnt;
        send_pkt(reply);
        wait_done(d0 + 1);
        check("r1_reply_ok", {31'd0, reply_ok}, 32'd1);
        check("r1_timed_out", {31'd0, timed_out}, 32'd0);
        check("r1_seq_num", {16'd0, seq_num}, 32'd0);
        check("r1_rtt", rtt_cycles, 32'(rx_eop_cyc - eop_cyc));
        check("r1_rtt_val", rtt_cycles, 32'd11);
        tick(3);
        check("r1_done_pulses", done_cnt - d0, 32'd1);
        check("r1_idle", {31'd0, busy}, 32'd0);

        // Second request (seq 1) under random backpressure
        tx_words.delete(); s0 = sop_cnt; e0 = eop_cnt; valid_drop = 0;
        pulse_start(5'd4);
        for (int k = 0; k < 2000 && eop_cnt == e0; k++) begin
            tx_ready = 1'($urandom_range(0, 1));
            tick(1);
        end
        tx_ready = 1'b1;
        wait_eop(e0 + 1);
        check("r2_seq_num", {16'd0, seq_num}, 32'd1);
        check("r2_w1", tx_words[1], 32'h0000_0100);
        check("r2_w2", tx_words[2], 32'hCE66_0140);
        check("r2_w5", tx_words[5], 32'h8AAD_0008);
        check("r2_w6", tx_words[6], 32'h0100_3412);
        diff = 0;
        for (int i = 0; i < 11; i++)
            if ((i == 0 || i == 3 || i == 4 || i >= 7) && tx_words[i] !== run1[i]) diff++;
        check("r2_same_as_nostall", diff, 32'd0);
        check("r2_no_valid_drop", valid_drop, 32'd0);
        check("r2_sop_cnt", sop_cnt - s0, 32'd1);
        make_reply(11);
        d0 = done_cnt;
        reply[6] = reply[6] ^ 32'h0000_FFFF;
        send_pkt(reply);
        tick(10);
        check("r2_no_done_on_bad", done_cnt - d0, 32'd0);
        reply[6] = reply[6] ^ 32'h0000_FFFF;
        send_pkt(reply);
        wait_done(d0 + 1);
        check("r2_reply_ok", {31'd0, reply_ok}, 32'd1);
        check("r2_rtt", rtt_cycles, 32'(rx_eop_cyc - eop_cyc));
        tick(3);
        check("r2_done_pulses", done_cnt - d0, 32'd1);

        // Timeout with an ignored start while waiting
        tx_words.delete(); s0 = sop_cnt; e0 = eop_cnt;
        pulse_start(5'd4);
        wait_eop(e0 + 1);
        d0 = done_cnt;
        tick(20);
        pulse_start(5'd4);
        tick(5);
        check("r3_busy_wait", {31'd0, busy}, 32'd1);
        wait_done(d0 + 1);
        check("r3_timeout_latency", done_cyc - eop_cyc, 32'd101);
        check("r3_timed_out", {31'd0, timed_out}, 32'd1);
        check("r3_reply_ok", {31'd0, reply_ok}, 32'd0);
        check("r3_rtt", rtt_cycles, 32'd100);
        check("r3_seq_num", {16'd0, seq_num}, 32'd2);
        tick(5);
        check("r3_flag_hold", {31'd0, timed_out}, 32'd1);
        check("r3_start_ignored", sop_cnt - s0, 32'd1);

        // Clamped payload: 31 words requested, 23-word packet
        tx_words.delete(); e0 = eop_cnt;
        pulse_start(5'd31);
        check("r4_flags_cleared", {31'd0, timed_out}, 32'd0);
        wait_eop(e0 + 1);
        check("r4_words", eop_cnt - e0, 32'd1);
        check("r4_w0", tx_words[0], 32'h5C00_0045);
        check("r4_w22", tx_words[22], 32'h3F3E_3D3C);
        check("r4_w23_absent", tx_words[23], 32'd0);
        check("r4_ip_sum", {16'd0, ocsum(tx_words, 0, 4)}, 32'h0000_FFFF);
        check("r4_icmp_sum", {16'd0, ocsum(tx_words, 5, 22)}, 32'h0000_FFFF);
        wait_done(done_cnt + 1);

        // Reset during S_SEND aborts; next request restarts at seq 0
        tx_words.delete();
        pulse_start(5'd31);
        for (int k = 0; k < 200 && tx_words.size() < 5; k++) tick(1);
        check("r5_in_send", {31'd0, tx_valid}, 32'd1);
        reset_n = 1'b0;
        #1;
        check("r5_rst_flags", {24'd0, busy, done, reply_ok, timed_out, tx_valid, tx_startofpacket, tx_endofpacket, rx_ready}, 32'd0);
        check("r5_rst_data", tx_data | rtt_cycles | {16'd0, seq_num}, 32'd0);
        tick(2);
        reset_n = 1'b1;
        tick(2);
        tx_words.delete(); e0 = eop_cnt;
        pulse_start(5'd4);
        wait_eop(e0 + 1);
        check("r6_seq_num", {16'd0, seq_num}, 32'd0);
        check("r6_w1", tx_words[1], 32'h0000_0000);
        diff = 0;
        for (int i = 0; i < 11; i++) if (tx_words[i] !== run1[i]) diff++;
        check("r6_same_as_r1", diff, 32'd0);
        make_reply(11);
        d0 = done_cnt;
        send_pkt(reply);
        wait_done(d0 + 1);
        check("r6_reply_ok", {31'd0, reply_ok}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
